// File: rtl/fp_packer_if.sv
// fp_packer_if: operand-in / result-out handshake bundle for fp_packer.
// "slave" is the packer side, "master" is the producer/consumer environment.
interface fp_packer_if #(
  parameter int N = 32
);
  logic          in_valid;
  logic          in_ready;
  logic          in_sign;
  logic [9:0]    in_exp;
  logic [N-1:0]  in_sig;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_result;
  logic          out_overflow;
  logic          out_underflow;
  logic          out_inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_sig, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_sig, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );
endinterface

// File: rtl/fp_packer.sv
// fp_packer: LZC / normalize / round-to-nearest-even pipeline packing to IEEE-754 single.
// Define FP_PACKER_SUBNORMAL_EN for gradual underflow; otherwise tiny results flush to signed zero.
module fp_packer #(
  parameter int N = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  fp_packer_if.slave bus
);
  localparam int LW = $clog2(N + 1);

  logic adv;
  logic out_valid_q;

  logic              s1_valid, s1_sign, s1_zero;
  logic [9:0]        s1_exp;
  logic [N-1:0]      s1_sig;
  logic [LW-1:0]     s1_lzc;

  logic              s2_valid, s2_sign, s2_zero, s2_tiny, s2_sticky;
  logic signed [10:0] s2_exp;
  logic [N-1:0]      s2_sig;

  logic              s3_valid, s3_sign, s3_zero, s3_tiny, s3_guard, s3_sticky;
  logic signed [10:0] s3_exp;
  logic [23:0]       s3_mant;

  // One enable for every stage: the whole pipe freezes while a result waits.
  assign adv           = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;

  function automatic logic [LW-1:0] count_lz(input logic [N-1:0] v);
    logic [LW-1:0] n;
    logic          found;
    n     = LW'(N);
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = LW'(N - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Stage 2 normalize (and optional denormalizing right shift).
  logic signed [10:0] exp_norm, exp_s2;
  logic [N-1:0]       sig_norm, sig_s2;
  logic               tiny, sticky_s2;
`ifdef FP_PACKER_SUBNORMAL_EN
  int                 sh;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    exp_norm  = 11'(signed'(s1_exp)) - signed'(11'(s1_lzc));
    sig_norm  = s1_sig << s1_lzc;
    tiny      = !s1_zero && (exp_norm <= 11'sd0);
    sig_s2    = sig_norm;
    exp_s2    = exp_norm;
    sticky_s2 = 1'b0;
`ifdef FP_PACKER_SUBNORMAL_EN
    sh = 0;
    if (tiny) begin
      sh = 1 - int'(exp_norm);
      if (sh > N) sh = N;
      for (int i = 0; i < N; i++) begin
        if (i < sh) sticky_s2 = sticky_s2 | sig_norm[i];
      end
      sig_s2 = sig_norm >> sh;
      exp_s2 = '0;
    end
`endif
  end

  // Stage 3 round-to-nearest-even and pack, registered into the result register.
  logic               inc, inexact;
  logic [24:0]        mant_r;
  logic signed [10:0] exp_r;
  logic [31:0]        result_c;
  logic               ovf_c, unf_c, inx_c;

  always_comb begin
    inc     = s3_guard & (s3_sticky | s3_mant[0]);
    mant_r  = {1'b0, s3_mant} + 25'(inc);
    exp_r   = s3_exp + signed'({10'd0, mant_r[24]});
    inexact = s3_guard | s3_sticky;
    // A subnormal that rounds up into bit 23 becomes the smallest normal.
    result_c = {s3_sign, (s3_tiny ? {7'd0, mant_r[23]} : exp_r[7:0]), mant_r[22:0]};
    ovf_c    = 1'b0;
    unf_c    = 1'b0;
    inx_c    = inexact;
    if (s3_zero) begin
      result_c = {s3_sign, 31'd0};
      inx_c    = 1'b0;
    end else if (s3_tiny) begin
`ifdef FP_PACKER_SUBNORMAL_EN
      unf_c = inexact;
`else
      result_c = {s3_sign, 31'd0};
      unf_c    = 1'b1;
      inx_c    = 1'b1;
`endif
    end else if (exp_r >= 11'sd255) begin
      result_c = {s3_sign, 8'hFF, 23'd0};
      ovf_c    = 1'b1;
      inx_c    = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid          <= 1'b0;
      s2_valid          <= 1'b0;
      s3_valid          <= 1'b0;
      out_valid_q       <= 1'b0;
      bus.out_result    <= '0;
      bus.out_overflow  <= 1'b0;
      bus.out_underflow <= 1'b0;
      bus.out_inexact   <= 1'b0;
    end else if (adv) begin
      s1_valid          <= bus.in_valid;
      s2_valid          <= s1_valid;
      s3_valid          <= s2_valid;
      out_valid_q       <= s3_valid;
      bus.out_result    <= result_c;
      bus.out_overflow  <= ovf_c;
      bus.out_underflow <= unf_c;
      bus.out_inexact   <= inx_c;
    end
  end

  // NOTE: datapath registers carry no reset; their contents are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign   <= bus.in_sign;
      s1_exp    <= bus.in_exp;
      s1_sig    <= bus.in_sig;
      s1_lzc    <= count_lz(bus.in_sig);
      s1_zero   <= (bus.in_sig == '0);

      s2_sign   <= s1_sign;
      s2_zero   <= s1_zero;
      s2_tiny   <= tiny;
      s2_exp    <= exp_s2;
      s2_sig    <= sig_s2;
      s2_sticky <= sticky_s2;

      s3_sign   <= s2_sign;
      s3_zero   <= s2_zero;
      s3_tiny   <= s2_tiny;
      s3_exp    <= s2_exp;
      s3_mant   <= s2_sig[N-1:N-24];
      s3_guard  <= s2_sig[N-25];
      s3_sticky <= s2_sticky | (|s2_sig[N-26:0]);
    end
  end
endmodule
